// File: rtl/fetch_pc_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction-memory address and pairs returned words with their PC.
// Optional FETCH_PERF_CNT_EN adds fetch/bubble performance counters.
module fetch_pc_stage #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(4)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              branch_taken_i,
    input  logic [ADDR_W-1:0] branch_target_i,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic [31:0]       imem_rdata_i,
    output logic [31:0]       instr_o,
    output logic [ADDR_W-1:0] pc_o,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0]       fetch_cnt_o,
    output logic [31:0]       bubble_cnt_o,
`endif
    output logic              instr_valid_o
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] infl_pc;
    logic              infl_v;

    // The memory re-samples infl_pc on every stall edge, so when the stall drops
    // its rdata already belongs to infl_pc and fetch can move on to fetch_pc.
    always_comb begin
        imem_addr_o = fetch_pc;
        if (branch_taken_i) begin
            imem_addr_o = branch_target_i;
        end else if (stall_i) begin
            imem_addr_o = infl_pc;
        end
    end

    always_comb begin
        state_nxt = state;
        if (branch_taken_i) begin
            state_nxt = RUN;
        end else if (stall_i) begin
            state_nxt = (state == BOOT) ? BOOT : HOLD;
        end else begin
            state_nxt = RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= BOOT;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc      <= RESET_PC;
            infl_pc       <= '0;
            infl_v        <= 1'b0;
            instr_o       <= '0;
            pc_o          <= '0;
            instr_valid_o <= 1'b0;
        end else if (branch_taken_i) begin
            // Flush the wrong-path word; instr_o/pc_o keep their last values.
            infl_pc       <= branch_target_i;
            infl_v        <= 1'b1;
            fetch_pc      <= branch_target_i + PC_STEP;
            instr_valid_o <= 1'b0;
        end else if (!stall_i) begin
            instr_o       <= imem_rdata_i;
            pc_o          <= infl_pc;
            instr_valid_o <= infl_v;
            infl_pc       <= imem_addr_o;
            infl_v        <= 1'b1;
            fetch_pc      <= imem_addr_o + PC_STEP;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt_o  <= '0;
            bubble_cnt_o <= '0;
        end else if (branch_taken_i || stall_i) begin
            bubble_cnt_o <= bubble_cnt_o + 32'd1;
        end else if (infl_v) begin
            fetch_cnt_o <= fetch_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_pc_stage.sv
// Scoreboard bench for fetch_pc_stage: a stream-level model predicts outputs after each edge; a monitor compares.
module tb_fetch_pc_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        instr_valid;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt;
    logic [31:0] bubble_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    fetch_pc_stage #(.ADDR_W(32), .RESET_PC(32'h0), .PC_STEP(32'h4)) dut (
        .clk            (clk),
        .rst            (rst),
        .stall_i        (stall),
        .branch_taken_i (branch_taken),
        .branch_target_i(branch_target),
        .imem_addr_o    (imem_addr),
        .imem_rdata_i   (imem_rdata),
        .instr_o        (instr),
        .pc_o           (pc),
`ifdef FETCH_PERF_CNT_EN
        .fetch_cnt_o    (fetch_cnt),
        .bubble_cnt_o   (bubble_cnt),
`endif
        .instr_valid_o  (instr_valid)
    );

    function automatic logic [31:0] memval(input logic [31:0] a);
        return 32'hA000_0000 + (a >> 2);
    endfunction

    // Registered-read bench memory.
    always @(posedge clk) imem_rdata <= memval(imem_addr);

    typedef struct {
        logic        v;
        logic        known;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] fc;
        logic [31:0] bc;
    } exp_t;

    exp_t q[$];

    // Stream-level model: which address is delivered next, and whether the
    // next sequential edge delivers it or is still priming the memory.
    logic        m_valid, m_known;
    logic [31:0] m_pc, m_instr, m_next;
    logic        m_primed;
    logic [31:0] m_fc, m_bc;

    task automatic model_edge(input logic r, input logic s, input logic b, input logic [31:0] t);
        if (r) begin
            m_valid = 0; m_known = 1; m_pc = 0; m_instr = 0;
            m_next = 32'h0; m_primed = 0; m_fc = 0; m_bc = 0;
        end else if (b) begin
            m_valid = 0; m_next = t; m_primed = 1; m_bc = m_bc + 1;
        end else if (s) begin
            m_bc = m_bc + 1;
        end else if (m_primed) begin
            m_valid = 1; m_known = 1; m_pc = m_next; m_instr = memval(m_next);
            m_next = m_next + 4; m_fc = m_fc + 1;
        end else begin
            m_valid = 0; m_known = 0; m_primed = 1;
        end
    endtask

    task automatic step(input logic r, input logic s, input logic b, input logic [31:0] t);
        exp_t e;
        rst = r; stall = s; branch_taken = b; branch_target = t;
        @(posedge clk);
        model_edge(r, s, b, t);
        e.v = m_valid; e.known = m_known; e.pc = m_pc; e.instr = m_instr;
        e.fc = m_fc; e.bc = m_bc;
        q.push_back(e);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: actual=%h required=%h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            check("instr_valid", {31'b0, instr_valid}, {31'b0, e.v});
            if (e.known) begin
                check("pc", pc, e.pc);
                check("instr", instr, e.instr);
            end
`ifdef FETCH_PERF_CNT_EN
            check("fetch_cnt", fetch_cnt, e.fc);
            check("bubble_cnt", bubble_cnt, e.bc);
`endif
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1; stall = 0; branch_taken = 0; branch_target = 0;
        m_valid = 0; m_known = 0; m_pc = 0; m_instr = 0; m_next = 0;
        m_primed = 0; m_fc = 0; m_bc = 0;
        @(posedge clk); #1;

        // Reset, sequential fetch, then branch to 0x40 while pc_o=0x8.
        repeat (3) step(1, 0, 0, 0);
        repeat (4) step(0, 0, 0, 0);
        step(0, 0, 1, 32'h40);
        repeat (3) step(0, 0, 0, 0);

        // Stall three cycles while pc_o=0xC, then release.
        repeat (3) step(1, 0, 0, 0);
        repeat (5) step(0, 0, 0, 0);
        repeat (3) step(0, 1, 0, 0);
        repeat (3) step(0, 0, 0, 0);

        // Branch and stall together: branch wins.
        step(0, 1, 1, 32'h100);
        repeat (3) step(0, 0, 0, 0);

        // Wrap at the top of the address space.
        step(0, 0, 1, 32'hFFFF_FFFC);
        repeat (3) step(0, 0, 0, 0);

        // Reset pulsed during a stall.
        repeat (2) step(0, 1, 0, 0);
        step(1, 1, 0, 0);
        repeat (4) step(0, 0, 0, 0);

        // 10 sequential fetches, one branch, two stall cycles.
        step(1, 0, 0, 0);
        repeat (11) step(0, 0, 0, 0);
        step(0, 0, 1, 32'h200);
        repeat (2) step(0, 1, 0, 0);

        // Randomized traffic.
        for (int i = 0; i < 800; i++) begin
            logic r, s, b;
            logic [31:0] t;
            r = ($urandom_range(0, 99) < 2);
            s = ($urandom_range(0, 99) < 20);
            b = ($urandom_range(0, 99) < 10);
            t = ($urandom_range(0, 3) == 0) ? $urandom() : {20'h0, $urandom_range(0, 1023), 2'b00};
            step(r, s, b, t);
        end

        @(negedge clk); #1;
        check("scoreboard_drained", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
